// File: rtl/sram_port_responder.sv
// Single-port synchronous SRAM model with a registered read port, one
// configurable injected fault (stuck-at-0/1 bit mask or address alias) and saturating access counters.
module sram_port_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_type,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'b00,
        FAULT_SA0   = 2'b01,
        FAULT_SA1   = 2'b10,
        FAULT_ALIAS = 2'b11
    } fault_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    fault_e                cfg_type_q, cfg_type_d;
    logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_WIDTH-1:0] cfg_mask_q, cfg_mask_d;
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  fault_hit;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_faulted;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wr_en     = !csb0 && !web0;
        rd_en     = !csb0 && web0;
        fault_hit = (addr0 == cfg_addr_q);

        // An alias fault redirects the faulty word to its LSB-flipped neighbour.
        eff_addr = addr0;
        if (cfg_type_q == FAULT_ALIAS && fault_hit) begin
            eff_addr = cfg_addr_q ^ {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end

        rd_word    = mem_q[eff_addr];
        rd_faulted = rd_word;
        if (fault_hit) begin
            case (cfg_type_q)
                FAULT_SA0: rd_faulted = rd_word & ~cfg_mask_q;
                FAULT_SA1: rd_faulted = rd_word | cfg_mask_q;
                default:   rd_faulted = rd_word;
            endcase
        end

        dout0_d = dout0_q;
        if (rd_en) begin
            dout0_d = rd_faulted;
        end

        wr_cnt_d = wr_cnt_q;
        if (wr_en && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        rd_cnt_d = rd_cnt_q;
        if (rd_en && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end

        // Same-edge accesses see the old configuration because they read the _q copies.
        cfg_type_d = cfg_type_q;
        cfg_addr_d = cfg_addr_q;
        cfg_mask_d = cfg_mask_q;
        if (cfg_load) begin
            cfg_type_d = fault_e'(cfg_type);
            cfg_addr_d = cfg_addr;
            cfg_mask_d = cfg_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_type_q <= FAULT_NONE;
            cfg_addr_q <= '0;
            cfg_mask_q <= '0;
            dout0_q    <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            cfg_type_q <= cfg_type_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_mask_q <= cfg_mask_d;
            dout0_q    <= dout0_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[eff_addr] <= din0;
        end
    end

    assign dout0  = dout0_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_sram_port_responder.sv
// Directed bench for sram_port_responder: fault injection, latency, idle hold,
// async reset and counter saturation, with hand-computed expected values.
module tb_sram_port_responder;

    logic        clk;
    logic        rst_n;
    logic        csb0;
    logic        web0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        cfg_load;
    logic [1:0]  cfg_type;
    logic [8:0]  cfg_addr;
    logic [31:0] cfg_mask;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    int checks;
    int errors;

    sram_port_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .csb0     (csb0),
        .web0     (web0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0),
        .cfg_load (cfg_load),
        .cfg_type (cfg_type),
        .cfg_addr (cfg_addr),
        .cfg_mask (cfg_mask),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle at the falling edge, then returns #1 after the rising edge.
    task automatic step(input logic cs, input logic we, input logic [8:0] a, input logic [31:0] d,
                        input logic ld, input logic [1:0] t, input logic [8:0] ca, input logic [31:0] m);
        @(negedge clk);
        csb0 = cs; web0 = we; addr0 = a; din0 = d;
        cfg_load = ld; cfg_type = t; cfg_addr = ca; cfg_mask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, a, d, 1'b0, 2'b00, 9'd0, 32'd0);
    endtask

    task automatic do_read(input logic [8:0] a);
        step(1'b0, 1'b1, a, 32'd0, 1'b0, 2'b00, 9'd0, 32'd0);
    endtask

    task automatic do_idle();
        step(1'b1, 1'b1, 9'd0, 32'd0, 1'b0, 2'b00, 9'd0, 32'd0);
    endtask

    task automatic do_cfg(input logic [1:0] t, input logic [8:0] ca, input logic [31:0] m);
        step(1'b1, 1'b1, 9'd0, 32'd0, 1'b1, t, ca, m);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0;
        cfg_load = 1'b0; cfg_type = 2'b00; cfg_addr = '0; cfg_mask = '0;
        #3;
        check("reset_dout", dout0, 32'h0);
        check("reset_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("reset_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word with zero, read all back.
        for (int i = 0; i < 512; i++) do_write(9'(i), 32'h0);
        for (int i = 0; i < 512; i++) begin
            do_read(9'(i));
            check("fill_read", dout0, 32'h0);
        end
        check("fill_wr_cnt", {16'd0, wr_cnt}, 32'd512);
        check("fill_rd_cnt", {16'd0, rd_cnt}, 32'd512);

        // Stuck-at-1 on bit 0 of address 5 only.
        do_cfg(2'b10, 9'd5, 32'h0000_0001);
        do_write(9'd5, 32'h0);
        do_write(9'd6, 32'h0);
        do_read(9'd5);
        check("sa1_addr5", dout0, 32'h0000_0001);
        do_read(9'd6);
        check("sa1_addr6", dout0, 32'h0000_0000);

        // Stuck-at-0 on bit 31 of address 7; clearing the fault restores stored data.
        do_cfg(2'b01, 9'd7, 32'h8000_0000);
        do_write(9'd7, 32'hFFFF_FFFF);
        do_read(9'd7);
        check("sa0_addr7", dout0, 32'h7FFF_FFFF);
        do_cfg(2'b00, 9'd0, 32'h0);
        do_read(9'd7);
        check("none_addr7", dout0, 32'hFFFF_FFFF);

        // Alias: address 2 maps to 3 for both writes and reads.
        do_cfg(2'b11, 9'd2, 32'h0);
        do_write(9'd2, 32'hAAAA_5555);
        do_read(9'd3);
        check("alias_read3", dout0, 32'hAAAA_5555);
        do_read(9'd2);
        check("alias_read2", dout0, 32'hAAAA_5555);
        check("alias_wr_cnt", {16'd0, wr_cnt}, 32'd516);
        check("alias_rd_cnt", {16'd0, rd_cnt}, 32'd518);
        do_cfg(2'b00, 9'd0, 32'h0);

        // Write then read next cycle, then idle cycles hold everything.
        do_write(9'd9, 32'h1234_5678);
        do_read(9'd9);
        check("wr_then_rd", dout0, 32'h1234_5678);
        do_write(9'd8, 32'hDEAD_BEEF);
        check("write_holds_dout", dout0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            do_idle();
            check("idle_hold", dout0, 32'h1234_5678);
        end
        check("idle_wr_cnt", {16'd0, wr_cnt}, 32'd518);
        check("idle_rd_cnt", {16'd0, rd_cnt}, 32'd519);

        // cfg_load on the same edge as a read: that read uses the old (none) config.
        step(1'b0, 1'b1, 9'd9, 32'd0, 1'b1, 2'b10, 9'd9, 32'h0000_000F);
        check("same_edge_old_cfg", dout0, 32'h1234_5678);
        do_read(9'd9);
        check("next_edge_new_cfg", dout0, 32'h1234_567F);
        do_read(9'd8);
        check("back_to_back_rd", dout0, 32'hDEAD_BEEF);

        // Reset mid read burst.
        do_read(9'd9);
        check("pre_reset_dout", dout0, 32'h1234_567F);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_dout", dout0, 32'h0);
        check("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        csb0 = 1'b1;

        // Array survives reset; fault config was cleared, so raw data comes back.
        do_read(9'd9);
        check("post_rst_array", dout0, 32'h1234_5678);
        check("post_rst_rd_cnt", {16'd0, rd_cnt}, 32'd1);

        // Saturate rd_cnt, then confirm it does not wrap.
        for (int i = 0; i < 65534; i++) do_read(9'd9);
        check("rd_cnt_at_max", {16'd0, rd_cnt}, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) do_read(9'd8);
        check("rd_cnt_saturated", {16'd0, rd_cnt}, 32'h0000_FFFF);
        check("sat_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("sat_last_read", dout0, 32'hDEAD_BEEF);

        do_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_responder.md
SRAM_PORT_RESPONDER -- requirements
Module: sram_port_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, address bits (depth = 2^ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port csb0  input  1  chip select, active-low.
REQ-006 SHALL have port web0  input  1  write enable, active-low (0 = write, 1 = read).
REQ-007 SHALL have port addr0  input  ADDR_WIDTH  access address.
REQ-008 SHALL have port din0  input  DATA_WIDTH  write data.
REQ-009 SHALL have port dout0  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port cfg_load  input  1  one-cycle pulse; captures fault configuration.
REQ-011 SHALL have port cfg_type  input  2  fault type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 address alias.
REQ-012 SHALL have port cfg_addr  input  ADDR_WIDTH  faulty word address.
REQ-013 SHALL have port cfg_mask  input  DATA_WIDTH  faulty bit mask (stuck-at types only).
REQ-014 SHALL have port wr_cnt  output  16  completed write count, saturating.
REQ-015 SHALL have port rd_cnt  output  16  completed read count, saturating.

Function
REQ-016 SHALL hold a storage array of 2^ADDR_WIDTH x DATA_WIDTH words; array contents are not reset.
REQ-017 SHALL sample csb0, web0, addr0 and din0 on each rising clk edge; csb0=1 means no access: dout0, array and counters hold.
REQ-018 SHALL, on write (csb0=0, web0=0), store din0 at the effective address; dout0 holds its previous value.
REQ-019 SHALL, on read (csb0=0, web0=1), load dout0 with the faulted word at the effective address; data visible one cycle after the sampling edge (latency 1).
REQ-020 SHALL, for back-to-back reads, update dout0 every cycle; a write to address A followed by a read of A on the next cycle SHALL return the new data.
REQ-021 SHALL compute the effective address as addr0, except when active type = 11 and addr0 == cfg_addr, in which case it is cfg_addr ^ 1 (LSB flipped) for both reads and writes.
REQ-022 SHALL, for type 01 at the fault address, return read data & ~mask; for type 10, return read data | mask; stored array data is unaffected; other addresses are unaffected.
REQ-023 SHALL apply type 00 as fault-free operation.
REQ-024 SHALL capture cfg_type, cfg_addr and cfg_mask on a cfg_load edge; the new configuration applies from the next edge onward; an access sampled on the same edge as cfg_load uses the old configuration.
REQ-025 SHALL increment wr_cnt per write and rd_cnt per read; each counter saturates at 16'hFFFF and does not wrap.
REQ-026 SHALL treat out-of-range conditions as impossible: every ADDR_WIDTH value is a valid address, so the block has no error output.

Reset
REQ-027 SHALL, while rst_n=0, force dout0=0, wr_cnt=0, rd_cnt=0 and active fault type=00 (mask=0, addr=0), asynchronously.
REQ-028 SHALL, when reset asserts mid-access, abort the access: no array update is guaranteed for that edge; the first access after rst_n deasserts behaves normally.
REQ-029 SHALL leave array contents undefined after power-up and unchanged by rst_n.

Verification
REQ-030 Bench SHALL cover: write 0x00000000 to all 512 addresses, read all -> every dout0 = 0x00000000 one cycle after each read edge, wr_cnt=512, rd_cnt=512.
REQ-031 Bench SHALL cover: cfg_load type=10, addr=5, mask=0x00000001; write 0 to addr 5 and addr 6, read both -> 0x00000001 from addr 5 and 0x00000000 from addr 6.
REQ-032 Bench SHALL cover: cfg_load type=01, addr=7, mask=0x80000000; write 0xFFFFFFFF to addr 7, read -> 0x7FFFFFFF; then cfg_load type=00, read addr 7 -> 0xFFFFFFFF.
REQ-033 Bench SHALL cover: cfg_load type=11, addr=2; write 0xAAAA5555 to addr 2, read addr 3 -> 0xAAAA5555; read addr 2 -> 0xAAAA5555.
REQ-034 Bench SHALL cover: write 0x12345678 to addr 9, then read addr 9 on the next cycle -> 0x12345678; then hold csb0=1 for 3 cycles -> dout0 stays 0x12345678.
REQ-035 Bench SHALL cover: assert rst_n low during a read burst -> dout0, wr_cnt, rd_cnt = 0 immediately; force rd_cnt to 0xFFFF with further reads after reset -> rd_cnt stays 0xFFFF.
